// File: rtl/corelet_pkg.sv
// Shared corelet definitions: default datapath widths and the drain controller state encoding.
package corelet_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned COL     = 8;
    localparam int unsigned ADDR_BW = 11;
    localparam int unsigned CNT_BW  = 11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/ofifo_drain_ctrl_if.sv
// OFIFO read port plus psum SRAM write port seen by the drain controller.
// master: the drain controller; slave: the OFIFO/SRAM side.
interface ofifo_drain_ctrl_if
    import corelet_pkg::*;
#(
    parameter int unsigned DataW = PSUM_BW * COL,
    parameter int unsigned AddrW = ADDR_BW
);

    logic             ofifo_valid;
    logic [DataW-1:0] ofifo_rdata;
    logic             ofifo_rd;
    logic             mem_cen;
    logic             mem_wen;
    logic [AddrW-1:0] mem_addr;
    logic [DataW-1:0] mem_wdata;

    modport master (
        input  ofifo_valid, ofifo_rdata,
        output ofifo_rd, mem_cen, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output ofifo_valid, ofifo_rdata,
        input  ofifo_rd, mem_cen, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ofifo_drain_ctrl.sv
// Drains num_rows OFIFO words into psum SRAM at base_addr, base_addr+1, ... (wrapping),
// one word per pop with a one-cycle registered write stage.
// Optional feature: define DRAIN_PERF_CNT_EN to add the stall_cnt output.
module ofifo_drain_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned col     = COL,
    parameter int unsigned addr_bw = ADDR_BW,
    parameter int unsigned cnt_bw  = CNT_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [cnt_bw-1:0]  num_rows,
    ofifo_drain_ctrl_if.master bus_io,
    output logic               busy,
    output logic               done
`ifdef DRAIN_PERF_CNT_EN
    ,
    output logic [cnt_bw-1:0]  stall_cnt
`endif
);

    localparam int unsigned DataW = psum_bw * col;

    drain_state_e       state_q, state_d;
    logic [addr_bw-1:0] base_q, base_d;
    logic [cnt_bw-1:0]  num_q, num_d;
    logic [cnt_bw-1:0]  idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [addr_bw-1:0] addr_q, addr_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic               pop;

    // State, transfer parameters and the write stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // FSM next state, pop decision and status outputs.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_rows;
                    idx_d   = '0;
                    state_d = (num_rows == '0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                busy = 1'b1;
                pop  = bus_io.ofifo_valid && (idx_q < num_q);
                if (pop) begin
                    idx_d = idx_q + cnt_bw'(1);
                    if (idx_q == num_q - cnt_bw'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // Last captured word is on the SRAM port this cycle.
                busy    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Write stage: a pop loads address/data; without a pop they hold and the SRAM is idle.
    always_comb begin
        wr_d    = pop;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (pop) begin
            // Truncating add wraps the address silently past the top of the SRAM.
            addr_d  = base_q + addr_bw'(idx_q);
            wdata_d = bus_io.ofifo_rdata;
        end
    end

    assign bus_io.ofifo_rd   = pop;
    assign bus_io.mem_cen    = ~wr_q;
    assign bus_io.mem_wen    = ~wr_q;
    assign bus_io.mem_addr   = addr_q;
    assign bus_io.mem_wdata  = wdata_q;

`ifdef DRAIN_PERF_CNT_EN
    logic [cnt_bw-1:0] stall_q, stall_d;

    // Stall counter next value: cleared by an accepted start, saturating count of starved DRAIN cycles.
    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && start) begin
            stall_d = '0;
        end else if (state_q == StDrain && !bus_io.ofifo_valid && stall_q != '1) begin
            stall_d = stall_q + cnt_bw'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Self-checking bench for ofifo_drain_ctrl: a table of directed transfers plus randomized transfers,
// checked per cycle against a FIFO/SRAM reference model. Define DRAIN_PERF_CNT_EN to also check stall_cnt.
module tb_ofifo_drain_ctrl;
    import corelet_pkg::*;

    localparam int unsigned DW = PSUM_BW * COL;
    localparam int unsigned AW = ADDR_BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CNT_BW-1:0] num_rows;
    logic              busy;
    logic              done;
`ifdef DRAIN_PERF_CNT_EN
    logic [CNT_BW-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ofifo_drain_ctrl_if #(.DataW(DW), .AddrW(AW)) bus ();

    ofifo_drain_ctrl #(
        .psum_bw (PSUM_BW),
        .col     (COL),
        .addr_bw (ADDR_BW),
        .cnt_bw  (CNT_BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .bus_io    (bus),
        .busy      (busy),
        .done      (done)
`ifdef DRAIN_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic [AW-1:0]     base;
        logic [CNT_BW-1:0] num;
        int                vmode;      // 0 always valid, 1 pattern, 2 random
        logic [15:0]       pat;        // per-cycle valid after start, LSB first
        int                restart_at; // pops before a second start, -1 none
        int                reset_at;   // pops before reset, -1 none
        int                exp_writes;
        logic [AW-1:0]     exp_last;
        int                exp_stall;
    } vec_t;

    int            checks = 0;
    int            fails  = 0;
    logic [DW-1:0] fifo_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: drive inputs after the falling edge, take the pop decision just before the
    // rising edge, look at registered outputs on the next falling edge.
    task automatic cycle(input logic st, input logic [AW-1:0] b, input logic [CNT_BW-1:0] n,
                         input logic v, input logic rs, output logic popped, output logic cen,
                         output logic wen, output logic [AW-1:0] wa, output logic [DW-1:0] wd,
                         output logic [DW-1:0] pw);
        start           = st;
        base_addr       = b;
        num_rows        = n;
        reset           = rs;
        bus.ofifo_valid = v && (fifo_q.size() != 0);
        bus.ofifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        popped = bus.ofifo_rd;
        pw     = bus.ofifo_rdata;
        chk("rd_without_valid", popped & ~bus.ofifo_valid, 1'b0);
        @(posedge clk);
        if (popped) void'(fifo_q.pop_front());
        @(negedge clk);
        cen = bus.mem_cen;
        wen = bus.mem_wen;
        wa  = bus.mem_addr;
        wd  = bus.mem_wdata;
    endtask

    task automatic transfer(input logic [AW-1:0] base, input logic [CNT_BW-1:0] num,
                            input int vmode, input logic [15:0] pat, input int restart_at,
                            input int reset_at, output int nwr, output logic [AW-1:0] last_addr);
        logic          popped, cen, wen, v, st, rs, restarted, finished;
        logic [AW-1:0] wa, ea;
        logic [DW-1:0] wd, pw;
        int            popcnt, stalls, pb;
        popcnt = 0; stalls = 0; restarted = 1'b0; finished = 1'b0;
        nwr = 0; last_addr = '0;
        fifo_q.delete();
        for (int i = 0; i < int'(num) + 4; i++) fifo_q.push_back(rand_word());

        cycle(1'b1, base, num, 1'b1, 1'b0, popped, cen, wen, wa, wd, pw);
        chk("start_no_pop", popped, 1'b0);
        chk("start_no_write", cen, 1'b1);
        chk("start_done", done, num == '0);
        chk("start_busy", busy, num != '0);

        if (num != '0) begin
            for (int k = 0; k < 400; k++) begin
                pb = popcnt;
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (k < 16) ? pat[k] : 1'b1;
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                st = 1'b0;
                rs = 1'b0;
                if (restart_at >= 0 && popcnt == restart_at && !restarted) begin
                    st = 1'b1;
                    restarted = 1'b1;
                end
                if (reset_at >= 0 && popcnt == reset_at) rs = 1'b1;
                if (pb < int'(num) && !v) stalls++;
                cycle(st, base ^ 11'h2AA, num + CNT_BW'(3), v, rs, popped, cen, wen, wa, wd, pw);
                if (rs) begin
                    chk("rst_cen", cen, 1'b1);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    cycle(1'b0, base, num, 1'b1, 1'b0, popped, cen, wen, wa, wd, pw);
                    chk("post_rst_rd", popped, 1'b0);
                    chk("post_rst_cen", cen, 1'b1);
                    chk("post_rst_busy", busy, 1'b0);
                    chk("post_rst_done", done, 1'b0);
`ifdef DRAIN_PERF_CNT_EN
                    chk("post_rst_stall", stall_cnt, '0);
`endif
                    finished = 1'b1;
                    break;
                end
                chk("pop", popped, v && (pb < int'(num)));
                if (popped) begin
                    ea = base + AW'(popcnt);
                    chk("wr_cen", cen, 1'b0);
                    chk("wr_wen", wen, 1'b0);
                    chk("wr_addr", wa, ea);
                    chk("wr_data", wd, pw);
                    nwr++;
                    last_addr = wa;
                    popcnt++;
                end else begin
                    chk("idle_cen", cen, 1'b1);
                    chk("idle_wen", wen, 1'b1);
                end
                chk("busy", busy, pb < int'(num));
                chk("done", done, pb == int'(num));
                if (pb == int'(num)) begin
                    finished = 1'b1;
                    break;
                end
            end
            chk("finished_in_budget", finished, 1'b1);
        end

        if (reset_at < 0) begin
`ifdef DRAIN_PERF_CNT_EN
            chk("stall_cnt_model", stall_cnt, stalls);
`endif
            // A start presented during the done cycle must be dropped.
            cycle(1'b1, base ^ 11'h0F0, CNT_BW'(5), 1'b1, 1'b0, popped, cen, wen, wa, wd, pw);
            chk("done_is_pulse", done, 1'b0);
            chk("done_start_busy", busy, 1'b0);
            chk("done_start_rd", popped, 1'b0);
            cycle(1'b0, base, num, 1'b1, 1'b0, popped, cen, wen, wa, wd, pw);
            chk("idle_busy", busy, 1'b0);
            chk("idle_rd", popped, 1'b0);
            chk("idle_no_write", cen, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        logic          popped, cen, wen;
        logic [AW-1:0] wa, last_addr, rb;
        logic [DW-1:0] wd, pw;
        logic [CNT_BW-1:0] rn;
        int            nwr, rr;

        vecs[0] = '{11'h010, 11'd4, 0, 16'h0000, -1, -1, 4, 11'h013, 0};
        vecs[1] = '{11'h020, 11'd3, 1, 16'h0019, -1, -1, 3, 11'h022, 2};
        vecs[2] = '{11'h030, 11'd0, 0, 16'h0000, -1, -1, 0, 11'h000, 0};
        vecs[3] = '{11'h7FE, 11'd4, 0, 16'h0000, -1, -1, 4, 11'h001, 0};
        vecs[4] = '{11'h100, 11'd8, 0, 16'h0000,  3, -1, 8, 11'h107, 0};
        vecs[5] = '{11'h200, 11'd8, 0, 16'h0000, -1,  5, 5, 11'h204, 0};
        vecs[6] = '{11'h300, 11'd8, 0, 16'h0000, -1, -1, 8, 11'h307, 0};

        bus.ofifo_valid = 1'b0;
        bus.ofifo_rdata = '0;
        start = 1'b0; base_addr = '0; num_rows = '0; reset = 1'b1;
        @(negedge clk);
        fifo_q.delete();
        fifo_q.push_back(rand_word());
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 11'h055, 11'd2, 1'b1, 1'b1, popped, cen, wen, wa, wd, pw);
        end
        chk("reset_rd", popped, 1'b0);
        chk("reset_cen", cen, 1'b1);
        chk("reset_wen", wen, 1'b1);
        chk("reset_addr", wa, '0);
        chk("reset_wdata", wd, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
`ifdef DRAIN_PERF_CNT_EN
        chk("reset_stall", stall_cnt, '0);
`endif

        for (int i = 0; i < 7; i++) begin
            transfer(vecs[i].base, vecs[i].num, vecs[i].vmode, vecs[i].pat, vecs[i].restart_at,
                     vecs[i].reset_at, nwr, last_addr);
            chk($sformatf("vec%0d_writes", i), nwr, vecs[i].exp_writes);
            if (vecs[i].exp_writes > 0) begin
                chk($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].exp_last);
            end
`ifdef DRAIN_PERF_CNT_EN
            if (vecs[i].reset_at < 0) begin
                chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].exp_stall);
            end
`endif
        end

        for (int i = 0; i < 20; i++) begin
            rb = AW'($urandom);
            rn = CNT_BW'($urandom_range(0, 12));
            rr = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : -1;
            transfer(rb, rn, 2, 16'h0000, rr, -1, nwr, last_addr);
            chk("rand_writes", nwr, int'(rn));
            if (rn != '0) chk("rand_last_addr", last_addr, rb + AW'(rn) - AW'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
